// File: rtl/uart_periph_if.sv
// uart_periph_if: APB slave bus bundle for the UART peripheral
interface uart_periph_if;
  logic [3:0]  PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  modport master(output PADDR, PWRITE, PENABLE, PSEL, PWDATA, input PRDATA, PREADY);
  modport slave(input PADDR, PWRITE, PENABLE, PSEL, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/uart_periph.sv
// uart_periph: APB UART with TX/RX FIFOs, 8N1 framing and programmable bit period
module uart_periph #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_RESET = 868
) (
  input  logic            PCLK,
  input  logic            PRESET,
  uart_periph_if.slave    apb,
  output logic            tx,
  input  logic            rx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [15:0] div;
  logic overrun;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_done, ovr_evt;
  logic setup_acc, acc, wr_tx, wr_div, rd_rx, rd_st;
  logic [1:0] sel;
  logic [31:0] status, rdata;
  state_t tx_st, tx_st_n, rx_st, rx_st_n;
  logic [15:0] tx_cnt, tx_div, rx_cnt, rx_div;
  logic [2:0] tx_bit, rx_bit;
  logic [7:0] tx_sh, rx_sh;
  logic tx_end, rx_adv;
  logic r1, r2, r3;
  logic unused;
  assign unused = ^{apb.PWDATA[31:16], apb.PADDR[1:0]};
  assign sel = apb.PADDR[3:2];
  // First access cycle captures read data; the PREADY cycle commits side effects once.
  assign setup_acc = apb.PSEL & apb.PENABLE & ~apb.PREADY;
  assign acc = apb.PSEL & apb.PENABLE & apb.PREADY;
  assign wr_tx = acc & apb.PWRITE & (sel == 2'd1);
  assign wr_div = acc & apb.PWRITE & (sel == 2'd3);
  assign rd_rx = acc & ~apb.PWRITE & (sel == 2'd2);
  assign rd_st = acc & ~apb.PWRITE & (sel == 2'd0);
  assign tx_empty = tx_wp == tx_rp;
  assign rx_empty = rx_wp == rx_rp;
  assign tx_full = (tx_wp ^ tx_rp) == {1'b1, {AW{1'b0}}};
  assign rx_full = (rx_wp ^ rx_rp) == {1'b1, {AW{1'b0}}};
  assign tx_push = wr_tx & (~tx_full | tx_pop);
  assign rx_pop = rd_rx & ~rx_empty;
  assign rx_push = rx_done & (~rx_full | rx_pop);
  assign ovr_evt = rx_done & rx_full & ~rx_pop;
  assign status = {26'd0, tx_st != IDLE, overrun, rx_full, rx_empty, tx_empty, tx_full};
  assign rdata = sel == 2'd0 ? status :
                 (sel == 2'd2 && !rx_empty) ? {24'd0, rx_mem[rx_rp[AW-1:0]]} :
                 sel == 2'd3 ? {16'd0, div} : 32'd0;
  assign tx = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : 1'b1;
  assign tx_end = tx_cnt == tx_div - 16'd1;
  assign rx_adv = rx_st == START ? rx_cnt == {1'b0, rx_div[15:1]} - 16'd1 : rx_cnt == rx_div - 16'd1;
  // APB response registers, divider, sticky overrun and FIFO pointers
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      apb.PREADY <= 1'b0;
      apb.PRDATA <= 32'd0;
      div <= 16'(DIV_RESET);
      overrun <= 1'b0;
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      apb.PREADY <= setup_acc;
      apb.PRDATA <= (setup_acc & ~apb.PWRITE) ? rdata : 32'd0;
      if (wr_div) div <= apb.PWDATA[15:0] < 16'd4 ? 16'd4 : apb.PWDATA[15:0];
      overrun <= ovr_evt | (overrun & ~rd_st);
      tx_wp <= tx_wp + {{AW{1'b0}}, tx_push};
      tx_rp <= tx_rp + {{AW{1'b0}}, tx_pop};
      rx_wp <= rx_wp + {{AW{1'b0}}, rx_push};
      rx_rp <= rx_rp + {{AW{1'b0}}, rx_pop};
    end
  end
  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= apb.PWDATA[7:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  end
  // TX next state; the end of STOP chains straight into the next START
  always_comb begin
    tx_st_n = tx_st;
    tx_pop = 1'b0;
    case (tx_st)
      IDLE: begin
        tx_pop = ~tx_empty;
        tx_st_n = tx_empty ? IDLE : START;
      end
      START: tx_st_n = tx_end ? DATA : START;
      DATA: tx_st_n = (tx_end && tx_bit == 3'd7) ? STOP : DATA;
      STOP: begin
        tx_pop = tx_end & ~tx_empty;
        tx_st_n = !tx_end ? STOP : tx_empty ? IDLE : START;
      end
    endcase
  end
  // TX state, bit timer, shifter; divider latched with each popped byte
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      tx_st <= IDLE;
      tx_cnt <= 16'd0;
      tx_div <= 16'd4;
      tx_bit <= 3'd0;
      tx_sh <= 8'd0;
    end else begin
      tx_st <= tx_st_n;
      tx_cnt <= (tx_st == IDLE || tx_end) ? 16'd0 : tx_cnt + 16'd1;
      tx_bit <= tx_st != DATA ? 3'd0 : tx_bit + {2'd0, tx_end};
      if (tx_pop) begin
        tx_sh <= tx_mem[tx_rp[AW-1:0]];
        tx_div <= div;
      end else if (tx_st == DATA && tx_end) tx_sh <= tx_sh >> 1;
    end
  end
  // RX next state; START samples mid-bit to reject glitches
  always_comb begin
    rx_st_n = rx_st;
    rx_done = 1'b0;
    case (rx_st)
      IDLE: rx_st_n = (r3 & ~r2) ? START : IDLE;
      START: rx_st_n = !rx_adv ? START : r2 ? IDLE : DATA;
      DATA: rx_st_n = (rx_adv && rx_bit == 3'd7) ? STOP : DATA;
      STOP: begin
        rx_done = rx_adv & r2;
        rx_st_n = rx_adv ? IDLE : STOP;
      end
    endcase
  end
  // RX synchronizer, state, timer and shifter; divider tracks DIV while idle
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      {r1, r2, r3} <= 3'b111;
      rx_st <= IDLE;
      rx_cnt <= 16'd0;
      rx_div <= 16'd4;
      rx_bit <= 3'd0;
      rx_sh <= 8'd0;
    end else begin
      {r1, r2, r3} <= {rx, r1, r2};
      rx_st <= rx_st_n;
      rx_cnt <= (rx_st == IDLE || rx_adv) ? 16'd0 : rx_cnt + 16'd1;
      rx_div <= rx_st == IDLE ? div : rx_div;
      rx_bit <= rx_st != DATA ? 3'd0 : rx_bit + {2'd0, rx_adv};
      if (rx_st == DATA && rx_adv) rx_sh <= {r2, rx_sh[7:1]};
    end
  end
endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: directed self-checking bench for the APB UART
module tb_uart_periph;
  localparam logic [3:0] A_ST = 4'h0, A_TX = 4'h4, A_RX = 4'h8, A_DIV = 4'hC;
  logic clk = 1'b0;
  logic PRESET;
  logic tx_o, rx_i, rx_drv, loop;
  int passed = 0, total = 0, cyc = 0;
  logic [31:0] q;
  logic ok;
  logic [7:0] mon_q[$];
  int mon_t[$];
  logic mon_en = 1'b0;
  int m_t;
  logic [7:0] m_b;
  uart_periph_if bus();
  assign rx_i = loop ? tx_o : rx_drv;
  uart_periph #(.FIFO_DEPTH(4), .DIV_RESET(868)) dut (
    .PCLK(clk), .PRESET(PRESET), .apb(bus.slave), .tx(tx_o), .rx(rx_i)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // serial monitor for DIV=8 frames on tx, sampling mid-bit
  always begin
    @(negedge clk);
    if (mon_en && tx_o === 1'b0) begin
      m_t = cyc;
      repeat (4) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (8) @(negedge clk);
        m_b[k] = tx_o;
      end
      repeat (8) @(negedge clk);
      if (tx_o === 1'b1) begin
        mon_q.push_back(m_b);
        mon_t.push_back(m_t);
      end
      repeat (3) @(negedge clk);
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic rdy_ok);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
    @(negedge clk);
    rdy_ok = bus.PREADY === 1'b0;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk);
    rdy_ok = rdy_ok & (bus.PREADY === 1'b0);
    @(negedge clk);
    rdy_ok = rdy_ok & (bus.PREADY === 1'b1);
    rd = bus.PRDATA;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    @(negedge clk);
    rdy_ok = rdy_ok & (bus.PREADY === 1'b0) & (bus.PRDATA === 32'd0);
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rx_drv = f[i];
      repeat (7) @(posedge clk);
    end
  endtask
  task automatic test_reset;
    #2 PRESET = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (tx_o !== 1'b1) $display("FAIL rst_tx got=%b exp=1", tx_o); else passed++;
    total++; if (bus.PREADY !== 1'b0) $display("FAIL rst_pready got=%b exp=0", bus.PREADY); else passed++;
    total++; if (bus.PRDATA !== 32'd0) $display("FAIL rst_prdata got=%h exp=0", bus.PRDATA); else passed++;
    @(posedge clk); #1 PRESET = 1'b1;
    apb(1'b1, A_TX, 32'h00, q, ok);
    repeat (10) @(negedge clk);
    total++; if (tx_o !== 1'b0) $display("FAIL midframe_tx got=%b exp=0", tx_o); else passed++;
    #2 PRESET = 1'b0;
    #1;
    total++; if (tx_o !== 1'b1) $display("FAIL async_rst_tx got=%b exp=1", tx_o); else passed++;
    @(posedge clk); #1 PRESET = 1'b1;
    apb(1'b0, A_ST, 32'd0, q, ok);
    total++; if (q !== 32'h06) $display("FAIL rst_status got=%h exp=%h", q, 32'h06); else passed++;
    total++; if (ok !== 1'b1) $display("FAIL rst_status_pready got=%b exp=1", ok); else passed++;
    apb(1'b0, A_DIV, 32'd0, q, ok);
    total++; if (q !== 32'd868) $display("FAIL rst_div got=%0d exp=868", q); else passed++;
    total++; if (ok !== 1'b1) $display("FAIL rst_div_pready got=%b exp=1", ok); else passed++;
    apb(1'b0, A_TX, 32'd0, q, ok);
    total++; if (q !== 32'd0) $display("FAIL txdata_read got=%h exp=0", q); else passed++;
  endtask
  task automatic test_tx_wave;
    logic [9:0] wave;
    logic [7:0] s;
    wave = {1'b1, 8'hA5, 1'b0};
    apb(1'b1, A_DIV, 32'd8, q, ok);
    apb(1'b1, A_TX, 32'hA5, q, ok);
    total++; if (tx_o !== 1'b1) $display("FAIL tx_latency_idle got=%b exp=1", tx_o); else passed++;
    for (int l = 0; l < 10; l++) begin
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        s[j] = tx_o;
      end
      total++;
      if (s !== {8{wave[l]}}) $display("FAIL tx_wave_bit%0d got=%b exp=%b", l, s, {8{wave[l]}});
      else passed++;
    end
    apb(1'b0, A_ST, 32'd0, q, ok);
    total++; if (q !== 32'h06) $display("FAIL tx_done_status got=%h exp=%h", q, 32'h06); else passed++;
  endtask
  task automatic test_back_to_back;
    mon_q.delete();
    mon_t.delete();
    mon_en = 1'b1;
    for (int i = 1; i <= 5; i++) apb(1'b1, A_TX, i, q, ok);
    apb(1'b0, A_ST, 32'd0, q, ok);
    total++; if (q !== 32'h25) $display("FAIL b2b_full_status got=%h exp=%h", q, 32'h25); else passed++;
    apb(1'b1, A_TX, 32'h06, q, ok);
    for (int i = 0; i < 700 && mon_q.size() < 5; i++) @(negedge clk);
    repeat (120) @(negedge clk);
    mon_en = 1'b0;
    total++; if (mon_q.size() !== 5) $display("FAIL b2b_count got=%0d exp=5", mon_q.size()); else passed++;
    for (int i = 0; i < mon_q.size(); i++) begin
      total++;
      if (mon_q[i] !== 8'(i + 1)) $display("FAIL b2b_byte%0d got=%h exp=%h", i, mon_q[i], 8'(i + 1));
      else passed++;
    end
    for (int i = 1; i < mon_t.size(); i++) begin
      total++;
      if (mon_t[i] - mon_t[i-1] !== 80) $display("FAIL b2b_gap%0d got=%0d exp=80", i, mon_t[i] - mon_t[i-1]);
      else passed++;
    end
  endtask
  task automatic test_loopback;
    loop = 1'b1;
    apb(1'b1, A_TX, 32'h3C, q, ok);
    repeat (100) @(negedge clk);
    apb(1'b0, A_ST, 32'd0, q, ok);
    total++; if (q !== 32'h02) $display("FAIL loop_status got=%h exp=%h", q, 32'h02); else passed++;
    apb(1'b0, A_RX, 32'd0, q, ok);
    total++; if (q !== 32'h3C) $display("FAIL loop_rxdata got=%h exp=%h", q, 32'h3C); else passed++;
    apb(1'b0, A_ST, 32'd0, q, ok);
    total++; if (q !== 32'h06) $display("FAIL loop_empty got=%h exp=%h", q, 32'h06); else passed++;
    loop = 1'b0;
  endtask
  task automatic test_overrun;
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    send_rx(8'h33, 1'b1);
    send_rx(8'h44, 1'b1);
    send_rx(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    apb(1'b0, A_ST, 32'd0, q, ok);
    total++; if (q !== 32'h1A) $display("FAIL ovr_status got=%h exp=%h", q, 32'h1A); else passed++;
    apb(1'b0, A_ST, 32'd0, q, ok);
    total++; if (q !== 32'h0A) $display("FAIL ovr_cleared got=%h exp=%h", q, 32'h0A); else passed++;
    for (int i = 0; i < 4; i++) begin
      apb(1'b0, A_RX, 32'd0, q, ok);
      total++;
      if (q !== {24'd0, exp_b[i]}) $display("FAIL ovr_rx%0d got=%h exp=%h", i, q, exp_b[i]);
      else passed++;
    end
    apb(1'b0, A_RX, 32'd0, q, ok);
    total++; if (q !== 32'd0) $display("FAIL rx_empty_read got=%h exp=0", q); else passed++;
    apb(1'b0, A_ST, 32'd0, q, ok);
    total++; if (q !== 32'h06) $display("FAIL ovr_drained got=%h exp=%h", q, 32'h06); else passed++;
  endtask
  task automatic test_errors;
    @(posedge clk); #1 rx_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    apb(1'b0, A_ST, 32'd0, q, ok);
    total++; if (q !== 32'h06) $display("FAIL glitch_status got=%h exp=%h", q, 32'h06); else passed++;
    send_rx(8'h55, 1'b0);
    @(posedge clk); #1 rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    apb(1'b0, A_ST, 32'd0, q, ok);
    total++; if (q !== 32'h06) $display("FAIL framing_status got=%h exp=%h", q, 32'h06); else passed++;
    send_rx(8'hA7, 1'b1);
    repeat (20) @(negedge clk);
    apb(1'b0, A_RX, 32'd0, q, ok);
    total++; if (q !== 32'hA7) $display("FAIL recover_rx got=%h exp=%h", q, 32'hA7); else passed++;
  endtask
  task automatic test_div;
    apb(1'b1, A_DIV, 32'd2, q, ok);
    apb(1'b0, A_DIV, 32'd0, q, ok);
    total++; if (q !== 32'd4) $display("FAIL div_clamp got=%0d exp=4", q); else passed++;
    apb(1'b1, A_DIV, 32'd5, q, ok);
    apb(1'b0, A_DIV, 32'd0, q, ok);
    total++; if (q !== 32'd5) $display("FAIL div_5 got=%0d exp=5", q); else passed++;
    apb(1'b1, A_DIV, 32'h0001_1234, q, ok);
    apb(1'b0, A_DIV, 32'd0, q, ok);
    total++; if (q !== 32'h1234) $display("FAIL div_mask got=%h exp=%h", q, 32'h1234); else passed++;
    apb(1'b1, A_ST, 32'hFF, q, ok);
    apb(1'b0, A_ST, 32'd0, q, ok);
    total++; if (q !== 32'h06) $display("FAIL status_ro got=%h exp=%h", q, 32'h06); else passed++;
  endtask
  initial begin
    PRESET = 1'b1;
    rx_drv = 1'b1;
    loop = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 4'h0; bus.PWDATA = 32'd0;
    test_reset;
    test_tx_wave;
    test_back_to_back;
    test_loopback;
    test_overrun;
    test_errors;
    test_div;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
